// File: rtl/board_ctrl.sv
// Board-level front panel controller: debounced buttons, CPU step/reset
// generation, channel view selection, LED mirror and 8-digit hex display scan.
module board_ctrl #(
   parameter int unsigned CH_N     = 2,
   parameter int unsigned DEB_CYC  = 500000,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned RUN_DIV  = 25000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_step,
   input  logic                 btn_cpu_rst,
   input  logic                 btn_mode,
   input  logic                 run_en,
   input  logic [32*CH_N-1:0]   ch_data,
   input  logic [7:0]           flags,
   output logic                 cpu_step,
   output logic                 cpu_reset,
   output logic [3:0]           view,
   output logic [2:0]           which,
   output logic [7:0]           seg,
   output logic [31:0]          led
);

   localparam int unsigned IN_N   = 4;
   localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
   localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
   localparam int unsigned RUN_W  = $clog2(RUN_DIV + 1);
   localparam int unsigned B_STEP = 0;
   localparam int unsigned B_RST  = 1;
   localparam int unsigned B_MODE = 2;
   localparam int unsigned B_RUN  = 3;

   logic [IN_N-1:0]   raw;
   logic [IN_N-1:0]   sync1;
   logic [IN_N-1:0]   sync2;
   logic [IN_N-1:0]   db;
   logic [IN_N-1:0]   db_nxt;
   logic [IN_N-1:0]   prev;
   logic [DEB_W-1:0]  deb_cnt     [IN_N];
   logic [DEB_W-1:0]  deb_cnt_nxt [IN_N];
   logic [RUN_W-1:0]  run_cnt;
   logic [RUN_W-1:0]  run_cnt_nxt;
   logic [SCAN_W-1:0] scan_cnt;
   logic [SCAN_W-1:0] scan_cnt_nxt;
   logic              press_step;
   logic              press_mode;
   logic              run_hit;
   logic              step_nxt;
   logic [3:0]        view_nxt;
   logic [2:0]        which_nxt;
   logic [31:0]       word_nxt;
   logic [3:0]        nib;
   logic [7:0]        seg_nxt;

   function automatic logic [7:0] hex_glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'h0: g = 8'hC0;
         4'h1: g = 8'hF9;
         4'h2: g = 8'hA4;
         4'h3: g = 8'hB0;
         4'h4: g = 8'h99;
         4'h5: g = 8'h92;
         4'h6: g = 8'h82;
         4'h7: g = 8'hF8;
         4'h8: g = 8'h80;
         4'h9: g = 8'h90;
         4'hA: g = 8'h88;
         4'hB: g = 8'h83;
         4'hC: g = 8'hC6;
         4'hD: g = 8'hA1;
         4'hE: g = 8'h86;
         default: g = 8'h8E;
      endcase
      return g;
   endfunction

   assign raw        = {run_en, btn_mode, btn_cpu_rst, btn_step};
   assign press_step = db[B_STEP] & ~prev[B_STEP];
   assign press_mode = db[B_MODE] & ~prev[B_MODE];

   // Debounce: accept a new level only after DEB_CYC consecutive differing samples.
   always_comb begin
      db_nxt      = db;
      deb_cnt_nxt = '{default: '0};
      for (int unsigned i = 0; i < IN_N; i++) begin
         if (sync2[i] != db[i]) begin
            if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
               db_nxt[i] = sync2[i];
            end else begin
               deb_cnt_nxt[i] = deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Step generation, view/scan advance; led and seg are built from the next
   // view/digit so that they move on the same edge as view and which.
   always_comb begin
      run_hit     = db[B_RUN] && (run_cnt == RUN_W'(RUN_DIV - 1));
      run_cnt_nxt = '0;
      if (db[B_RUN] && !run_hit) begin
         run_cnt_nxt = run_cnt + RUN_W'(1);
      end
      step_nxt = ~db[B_RST] & ((press_step & ~db[B_RUN]) | run_hit);

      view_nxt = view;
      if (press_mode) begin
         view_nxt = (view == 4'(CH_N)) ? 4'd0 : view + 4'd1;
      end

      scan_cnt_nxt = scan_cnt + SCAN_W'(1);
      which_nxt    = which;
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt_nxt = '0;
         which_nxt    = which + 3'd1;
      end

      word_nxt = {24'b0, flags};
      for (int unsigned k = 0; k < CH_N; k++) begin
         if (view_nxt == 4'(k)) begin
            word_nxt = ch_data[32*k +: 32];
         end
      end
      nib     = 4'(word_nxt >> {which_nxt, 2'b00});
      seg_nxt = hex_glyph(nib);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         db        <= '0;
         prev      <= '0;
         deb_cnt   <= '{default: '0};
         run_cnt   <= '0;
         scan_cnt  <= '0;
         cpu_step  <= 1'b0;
         cpu_reset <= 1'b1;
         view      <= '0;
         which     <= '0;
         seg       <= 8'hFF;
         led       <= '0;
      end else begin
         sync1     <= raw;
         sync2     <= sync1;
         db        <= db_nxt;
         prev      <= db;
         deb_cnt   <= deb_cnt_nxt;
         run_cnt   <= run_cnt_nxt;
         scan_cnt  <= scan_cnt_nxt;
         cpu_step  <= step_nxt;
         cpu_reset <= db[B_RST];
         view      <= view_nxt;
         which     <= which_nxt;
         seg       <= seg_nxt;
         led       <= word_nxt;
      end
   end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed self-checking bench for board_ctrl with small timing parameters.
module tb_board_ctrl;

   logic        clk;
   logic        reset;
   logic        btn_step;
   logic        btn_cpu_rst;
   logic        btn_mode;
   logic        run_en;
   logic [63:0] ch_data;
   logic [7:0]  flags;
   logic        cpu_step;
   logic        cpu_reset;
   logic [3:0]  view;
   logic [2:0]  which;
   logic [7:0]  seg;
   logic [31:0] led;

   int total;
   int bad;

   logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   board_ctrl #(.CH_N(2), .DEB_CYC(4), .SCAN_DIV(2), .RUN_DIV(8)) dut (
      .clk(clk), .reset(reset), .btn_step(btn_step), .btn_cpu_rst(btn_cpu_rst),
      .btn_mode(btn_mode), .run_en(run_en), .ch_data(ch_data), .flags(flags),
      .cpu_step(cpu_step), .cpu_reset(cpu_reset), .view(view), .which(which),
      .seg(seg), .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold btn_mode long enough to debounce, then release; reports the tick of the view change.
   task automatic do_mode_press(output int at);
      logic [3:0] v0;
      v0 = view;
      at = -1;
      btn_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (at < 0 && view !== v0) at = i;
      end
      btn_mode = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total++; if (view !== 4'd0) begin bad++; $display("FAIL reset_view got=%h want=0", view); end
      total++; if (which !== 3'd0) begin bad++; $display("FAIL reset_which got=%h want=0", which); end
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=FF", seg); end
      total++; if (led !== 32'h0) begin bad++; $display("FAIL reset_led got=%h want=0", led); end
      total++; if (cpu_step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", cpu_step); end
      total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpurst got=%b want=1", cpu_reset); end
      reset = 1'b0;
      tick();
      total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL post_reset_cpurst got=%b want=0", cpu_reset); end
      total++; if (led !== 32'h01234567) begin bad++; $display("FAIL post_reset_led got=%h want=01234567", led); end
   endtask

   task automatic test_bounce();
      int n_tog, n_hold, n_after, at;
      n_tog = 0; n_hold = 0; n_after = 0; at = -1;
      for (int i = 0; i < 20; i++) begin
         btn_step = ((i / 2) % 2) == 0;
         tick();
         if (cpu_step) n_tog++;
      end
      btn_step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cpu_step) begin n_hold++; at = i; end
      end
      btn_step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cpu_step) n_after++;
      end
      total++; if (n_tog !== 0) begin bad++; $display("FAIL bounce_toggle_pulses got=%0d want=0", n_tog); end
      total++; if (n_hold !== 1) begin bad++; $display("FAIL bounce_hold_pulses got=%0d want=1", n_hold); end
      total++; if (at !== 6) begin bad++; $display("FAIL bounce_pulse_tick got=%0d want=6", at); end
      total++; if (n_after !== 0) begin bad++; $display("FAIL bounce_release_pulses got=%0d want=0", n_after); end
   endtask

   task automatic test_free_run();
      int pt [8];
      int n;
      n = 0;
      run_en = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < 40; i++) begin
         if (i == 10) btn_step = 1'b1;
         if (i == 26) btn_step = 1'b0;
         tick();
         if (cpu_step) begin
            if (n < 8) pt[n] = i;
            n++;
         end
      end
      total++; if (n !== 5) begin bad++; $display("FAIL run_pulse_count got=%0d want=5", n); end
      for (int k = 1; k < n && k < 8; k++) begin
         total++;
         if (pt[k] - pt[k-1] !== 8) begin
            bad++; $display("FAIL run_pulse_gap%0d got=%0d want=8", k, pt[k] - pt[k-1]);
         end
      end
      run_en = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_view_wrap();
      int at;
      total++; if (view !== 4'd0) begin bad++; $display("FAIL wrap_start_view got=%h want=0", view); end
      do_mode_press(at);
      total++; if (at !== 6) begin bad++; $display("FAIL wrap_view_tick got=%0d want=6", at); end
      total++; if (view !== 4'd1) begin bad++; $display("FAIL wrap_view1 got=%h want=1", view); end
      total++; if (led !== 32'h89ABCDEF) begin bad++; $display("FAIL wrap_led1 got=%h want=89ABCDEF", led); end
      do_mode_press(at);
      total++; if (view !== 4'd2) begin bad++; $display("FAIL wrap_view2 got=%h want=2", view); end
      total++; if (led !== 32'h00000003) begin bad++; $display("FAIL wrap_led2 got=%h want=00000003", led); end
      do_mode_press(at);
      total++; if (view !== 4'd0) begin bad++; $display("FAIL wrap_view0 got=%h want=0", view); end
      total++; if (led !== 32'h01234567) begin bad++; $display("FAIL wrap_led0 got=%h want=01234567", led); end
   endtask

   task automatic test_scan();
      int found;
      logic [2:0]  pw;
      logic [2:0]  ew;
      logic [31:0] word;
      logic [3:0]  dig;
      word = 32'h01234567;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         pw = which;
         tick();
         if (pw == 3'd7 && which == 3'd0) found = 1;
      end
      total++; if (found !== 1) begin bad++; $display("FAIL scan_wrap_seen got=%0d want=1", found); end
      for (int j = 0; j < 16; j++) begin
         ew  = 3'(j / 2);
         dig = 4'(word >> (4 * ew));
         total++;
         if (which !== ew) begin bad++; $display("FAIL scan_which j=%0d got=%h want=%h", j, which, ew); end
         total++;
         if (seg !== glyph[dig]) begin bad++; $display("FAIL scan_seg j=%0d got=%h want=%h", j, seg, glyph[dig]); end
         tick();
      end
   endtask

   task automatic test_cpu_reset();
      int n;
      n = 0;
      btn_cpu_rst = 1'b1;
      btn_step    = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu_step) n++;
         if (i == 5) begin
            total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL cpurst_early got=%b want=0", cpu_reset); end
         end
         if (i == 6) begin
            total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL cpurst_asserted got=%b want=1", cpu_reset); end
         end
      end
      btn_cpu_rst = 1'b0;
      btn_step    = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu_step) n++;
      end
      total++; if (n !== 0) begin bad++; $display("FAIL cpurst_step_pulses got=%0d want=0", n); end
      total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL cpurst_released got=%b want=0", cpu_reset); end
   endtask

   task automatic test_reset_mid();
      int at, found, first;
      do_mode_press(at);
      do_mode_press(at);
      total++; if (view !== 4'd2) begin bad++; $display("FAIL mid_pre_view got=%h want=2", view); end
      run_en = 1'b1;
      repeat (10) tick();
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (cpu_step) found = 1;
      end
      total++; if (found !== 1) begin bad++; $display("FAIL mid_run_pulse_seen got=%0d want=1", found); end
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (view !== 4'd0) begin bad++; $display("FAIL mid_view got=%h want=0", view); end
      total++; if (led !== 32'h0) begin bad++; $display("FAIL mid_led got=%h want=0", led); end
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL mid_seg got=%h want=FF", seg); end
      total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_cpurst got=%b want=1", cpu_reset); end
      // run_en is re-accepted 2+DEB_CYC edges after release, then RUN_DIV edges to the pulse
      first = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (first < 0 && cpu_step) first = i;
      end
      total++; if (first !== 14) begin bad++; $display("FAIL mid_first_step got=%0d want=14", first); end
      run_en = 1'b0;
      repeat (12) tick();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      reset       = 1'b1;
      btn_step    = 1'b0;
      btn_cpu_rst = 1'b0;
      btn_mode    = 1'b0;
      run_en      = 1'b0;
      ch_data     = {32'h89ABCDEF, 32'h01234567};
      flags       = 8'h03;
      test_reset();
      test_bounce();
      test_free_run();
      test_view_wrap();
      test_scan();
      test_cpu_reset();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
